upgrade_pickup_manager: RTL and testbench

Parametrised successor to the single-pickup speed latch. Tracks NUM_PICKUPS pickups against NUM_PLAYERS players, once per frame. Grants a timed effect that expires, and respawns each pickup after a delay. Sits between the ball/player motion blocks and the colour mapper / speed logic, clocked by frame_clk.

---
 rtl/upgrade_pickup_manager.sv | 175 +++++++++++++++++
 tb/tb_upgrade_pickup_manager.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/upgrade_pickup_manager.sv
// upgrade_pickup_manager: tracks NUM_PICKUPS pickups against NUM_PLAYERS
// players once per frame, grants a timed upgrade effect to the collecting
// player and respawns each pickup after RESPAWN_FRAMES frames.
// Optional build macro: UPGRADE_STACK_EN (credits while active add time,
// saturating, instead of restarting the effect timer).
module upgrade_pickup_manager #(
  parameter int NUM_PLAYERS    = 2,
  parameter int NUM_PICKUPS    = 4,
  parameter int COORD_W        = 10,
  parameter int TIMER_W        = 10,
  parameter int EFFECT_FRAMES  = 600,
  parameter int RESPAWN_FRAMES = 300
) (
  input  logic                           frame_clk,
  input  logic                           Reset,
  input  logic                           game_active,
  input  logic [NUM_PLAYERS*COORD_W-1:0] player_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0] player_y,
  input  logic [COORD_W-1:0]             player_size,
  input  logic [NUM_PICKUPS*COORD_W-1:0] pickup_x,
  input  logic [NUM_PICKUPS*COORD_W-1:0] pickup_y,
  input  logic [COORD_W-1:0]             pickup_size,
  output logic [NUM_PICKUPS-1:0]         pickup_visible,
  output logic [NUM_PICKUPS-1:0]         collect_pulse,
  output logic [NUM_PLAYERS-1:0]         effect_active,
  output logic [NUM_PLAYERS*TIMER_W-1:0] effect_remaining
);

  typedef enum logic {AVAILABLE, COOLDOWN} pickup_state_t;

  localparam logic [TIMER_W-1:0] EFFECT_LOAD  = TIMER_W'(EFFECT_FRAMES);
  localparam logic [TIMER_W-1:0] RESPAWN_LOAD = TIMER_W'(RESPAWN_FRAMES);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

  pickup_state_t                state [NUM_PICKUPS];
  pickup_state_t                state_next [NUM_PICKUPS];
  logic [TIMER_W-1:0]           respawn_cnt [NUM_PICKUPS];
  logic [TIMER_W-1:0]           respawn_next [NUM_PICKUPS];
  logic [TIMER_W-1:0]           timer [NUM_PLAYERS];
  logic [TIMER_W-1:0]           timer_next [NUM_PLAYERS];
  logic [NUM_PICKUPS-1:0]       pulse_next;
  logic [NUM_PLAYERS-1:0]       credit;
  logic [NUM_PLAYERS-1:0][NUM_PICKUPS-1:0] hit;

  logic [COORD_W:0] reach;
  logic [COORD_W:0] px, py, ux, uy, dx, dy;
  logic             found;
  logic [TIMER_W:0] stack_sum;

  // Box overlap test per player/pickup pair, using one extra bit so the
  // absolute difference and the summed half-sizes never wrap.
  always_comb begin
    reach = {1'b0, player_size} + {1'b0, pickup_size};
    px = '0;
    py = '0;
    ux = '0;
    uy = '0;
    dx = '0;
    dy = '0;
    hit = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      for (int j = 0; j < NUM_PICKUPS; j++) begin
        px = {1'b0, player_x[i*COORD_W +: COORD_W]};
        py = {1'b0, player_y[i*COORD_W +: COORD_W]};
        ux = {1'b0, pickup_x[j*COORD_W +: COORD_W]};
        uy = {1'b0, pickup_y[j*COORD_W +: COORD_W]};
        dx = (px >= ux) ? (px - ux) : (ux - px);
        dy = (py >= uy) ? (py - uy) : (uy - py);
        hit[i][j] = (dx <= reach) && (dy <= reach);
      end
    end
  end

  // Pickup FSM next state: lowest-index hitter wins an available pickup,
  // cooldown counts down and returns the pickup on the frame it reads 1.
  always_comb begin
    state_next   = state;
    respawn_next = respawn_cnt;
    pulse_next   = '0;
    credit       = '0;
    found        = 1'b0;
    for (int j = 0; j < NUM_PICKUPS; j++) begin
      found = 1'b0;
      case (state[j])
        AVAILABLE: begin
          if (game_active) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (hit[i][j] && !found) begin
                found     = 1'b1;
                credit[i] = 1'b1;
              end
            end
            if (found) begin
              state_next[j]   = COOLDOWN;
              respawn_next[j] = RESPAWN_LOAD;
              pulse_next[j]   = 1'b1;
            end
          end
        end
        COOLDOWN: begin
          if (game_active && (respawn_cnt[j] != '0)) begin
            respawn_next[j] = respawn_cnt[j] - TIMER_ONE;
            if (respawn_cnt[j] == TIMER_ONE) begin
              state_next[j] = AVAILABLE;
            end
          end
        end
        default: state_next[j] = AVAILABLE;
      endcase
    end
  end

  // Effect timers: a credit loads (or stacks onto) the timer and takes
  // priority over the per-frame countdown.
  always_comb begin
    timer_next = timer;
    stack_sum  = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (game_active) begin
        if (credit[i]) begin
`ifdef UPGRADE_STACK_EN
          if (timer[i] != '0) begin
            stack_sum     = {1'b0, timer[i]} + {1'b0, EFFECT_LOAD};
            timer_next[i] = stack_sum[TIMER_W] ? '1 : stack_sum[TIMER_W-1:0];
          end else begin
            timer_next[i] = EFFECT_LOAD;
          end
`else
          timer_next[i] = EFFECT_LOAD;
`endif
        end else if (timer[i] != '0) begin
          timer_next[i] = timer[i] - TIMER_ONE;
        end
      end
    end
  end

  // State registers; Reset overrides every other update.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      for (int j = 0; j < NUM_PICKUPS; j++) begin
        state[j]       <= AVAILABLE;
        respawn_cnt[j] <= '0;
      end
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        timer[i] <= '0;
      end
      collect_pulse <= '0;
      effect_active <= '0;
    end else begin
      for (int j = 0; j < NUM_PICKUPS; j++) begin
        state[j]       <= state_next[j];
        respawn_cnt[j] <= respawn_next[j];
      end
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        timer[i]         <= timer_next[i];
        effect_active[i] <= (timer_next[i] != '0);
      end
      collect_pulse <= pulse_next;
    end
  end

  // Output decode of the registered state.
  always_comb begin
    pickup_visible   = '0;
    effect_remaining = '0;
    for (int j = 0; j < NUM_PICKUPS; j++) begin
      pickup_visible[j] = (state[j] == AVAILABLE);
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      effect_remaining[i*TIMER_W +: TIMER_W] = timer[i];
    end
  end

endmodule

// File: tb/tb_upgrade_pickup_manager.sv
// tb_upgrade_pickup_manager: directed and randomized checks of
// upgrade_pickup_manager against a frame-level behavioural model.
module tb_upgrade_pickup_manager;

  localparam int NPL = 2;
  localparam int NPK = 4;
  localparam int CW  = 10;
  localparam int TW  = 10;
  localparam int EFF = 5;
  localparam int RSP = 3;

  logic              frame_clk = 1'b0;
  logic              Reset;
  logic              game_active;
  logic [NPL*CW-1:0] player_x, player_y;
  logic [CW-1:0]     player_size, pickup_size;
  logic [NPK*CW-1:0] pickup_x, pickup_y;
  logic [NPK-1:0]    pickup_visible, collect_pulse;
  logic [NPL-1:0]    effect_active;
  logic [NPL*TW-1:0] effect_remaining;

  int tests_run = 0;
  int tests_failed = 0;

  // Stimulus values and model state, kept as plain integers.
  int px [NPL], py [NPL], ux [NPK], uy [NPK];
  int psz, usz;
  bit rst, ga;
  bit m_vis [NPK];
  bit m_pulse [NPK];
  int m_cnt [NPK];
  int m_tmr [NPL];

  upgrade_pickup_manager #(
    .NUM_PLAYERS(NPL), .NUM_PICKUPS(NPK), .COORD_W(CW), .TIMER_W(TW),
    .EFFECT_FRAMES(EFF), .RESPAWN_FRAMES(RSP)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .game_active(game_active),
    .player_x(player_x), .player_y(player_y), .player_size(player_size),
    .pickup_x(pickup_x), .pickup_y(pickup_y), .pickup_size(pickup_size),
    .pickup_visible(pickup_visible), .collect_pulse(collect_pulse),
    .effect_active(effect_active), .effect_remaining(effect_remaining)
  );

  // Free-running frame clock.
  always #5 frame_clk = ~frame_clk;

  function automatic int absDiff(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit modelHit(int i, int j);
    return (absDiff(px[i], ux[j]) <= psz + usz) && (absDiff(py[i], uy[j]) <= psz + usz);
  endfunction

  // One frame of the reference behaviour, using the inputs about to be sampled.
  task automatic modelStep();
    bit cred [NPL];
    int win;
    foreach (cred[i]) cred[i] = 0;
    if (rst) begin
      foreach (m_vis[j]) begin
        m_vis[j] = 1; m_cnt[j] = 0; m_pulse[j] = 0;
      end
      foreach (m_tmr[i]) m_tmr[i] = 0;
    end else if (!ga) begin
      foreach (m_pulse[j]) m_pulse[j] = 0;
    end else begin
      for (int j = 0; j < NPK; j++) begin
        m_pulse[j] = 0;
        if (m_vis[j]) begin
          win = -1;
          for (int i = NPL - 1; i >= 0; i--) if (modelHit(i, j)) win = i;
          if (win >= 0) begin
            m_vis[j] = 0; m_cnt[j] = RSP; m_pulse[j] = 1; cred[win] = 1;
          end
        end else if (m_cnt[j] == 1) begin
          m_vis[j] = 1; m_cnt[j] = 0;
        end else if (m_cnt[j] > 1) begin
          m_cnt[j]--;
        end
      end
      for (int i = 0; i < NPL; i++) begin
        if (cred[i]) begin
`ifdef UPGRADE_STACK_EN
          if (m_tmr[i] > 0) m_tmr[i] = (m_tmr[i] + EFF > (1 << TW) - 1) ? (1 << TW) - 1 : m_tmr[i] + EFF;
          else m_tmr[i] = EFF;
`else
          m_tmr[i] = EFF;
`endif
        end else if (m_tmr[i] > 0) begin
          m_tmr[i]--;
        end
      end
    end
  endtask

  // Drive the current stimulus, advance the model and the DUT one frame.
  task automatic applyStimulus();
    Reset = rst;
    game_active = ga;
    player_size = CW'(psz);
    pickup_size = CW'(usz);
    for (int i = 0; i < NPL; i++) begin
      player_x[i*CW +: CW] = CW'(px[i]);
      player_y[i*CW +: CW] = CW'(py[i]);
    end
    for (int j = 0; j < NPK; j++) begin
      pickup_x[j*CW +: CW] = CW'(ux[j]);
      pickup_y[j*CW +: CW] = CW'(uy[j]);
    end
    modelStep();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic checkValue(string tag, logic [31:0] obs, logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model.
  task automatic checkOutput(string tag);
    logic [NPK-1:0]    e_vis, e_pulse;
    logic [NPL-1:0]    e_act;
    logic [NPL*TW-1:0] e_rem;
    for (int j = 0; j < NPK; j++) begin
      e_vis[j] = m_vis[j];
      e_pulse[j] = m_pulse[j];
    end
    for (int i = 0; i < NPL; i++) begin
      e_act[i] = (m_tmr[i] != 0);
      e_rem[i*TW +: TW] = TW'(m_tmr[i]);
    end
    checkValue({tag, "_visible"}, 32'(pickup_visible), 32'(e_vis));
    checkValue({tag, "_pulse"}, 32'(collect_pulse), 32'(e_pulse));
    checkValue({tag, "_active"}, 32'(effect_active), 32'(e_act));
    checkValue({tag, "_remaining"}, 32'(effect_remaining), 32'(e_rem));
  endtask

  task automatic parkAll();
    for (int i = 0; i < NPL; i++) begin
      px[i] = 1000; py[i] = 50 + 100 * i;
    end
    for (int j = 0; j < NPK; j++) begin
      ux[j] = 200 + 150 * j; uy[j] = 800;
    end
    psz = 4; usz = 4;
  endtask

  function automatic int remOf(int i);
    logic [NPL*TW-1:0] r;
    r = effect_remaining;
    return int'(r[i*TW +: TW]);
  endfunction

  initial begin
    int stack_exp;
    parkAll();
    rst = 1; ga = 1;
    applyStimulus();
    checkOutput("reset");
    checkValue("reset_all_visible", 32'(pickup_visible), 32'hF);
    rst = 0;
    applyStimulus();
    checkOutput("idle");

    // Single collection.
    px[0] = 100; py[0] = 100; ux[0] = 104; uy[0] = 100;
    applyStimulus();
    checkOutput("t1_collect");
    checkValue("t1_pulse0", 32'(collect_pulse), 32'h1);
    checkValue("t1_rem0", 32'(remOf(0)), 32'(EFF));
    parkAll();
    applyStimulus();
    checkOutput("t1_after");

    // Two players on the same pickup.
    px[0] = 500; py[0] = 800; px[1] = 502; py[1] = 800;
    applyStimulus();
    checkOutput("t2_tie");
    checkValue("t2_pulse", 32'(collect_pulse), 32'h4);
    checkValue("t2_rem1", 32'(remOf(1)), 32'd0);
    parkAll();

    // Respawn timing with the player held on the pickup.
    px[1] = 350; py[1] = 800;
    applyStimulus();
    checkOutput("t3_k");
    for (int n = 1; n <= 4; n++) begin
      applyStimulus();
      checkOutput($sformatf("t3_k%0d", n));
      if (n == 3) checkValue("t3_respawned", 32'(pickup_visible[1]), 32'd1);
      if (n == 4) checkValue("t3_recollect", 32'(collect_pulse[1]), 32'd1);
    end
    parkAll();

    // Countdown then re-collect at remaining 2.
    for (int n = 0; n < 3; n++) begin
      applyStimulus();
      checkOutput($sformatf("t4_count%0d", n));
    end
    px[1] = 650; py[1] = 800;
    applyStimulus();
    checkOutput("t4_recredit");
`ifdef UPGRADE_STACK_EN
    stack_exp = EFF + 2;
`else
    stack_exp = EFF;
`endif
    checkValue("t4_reload_value", 32'(remOf(1)), 32'(stack_exp));
    parkAll();
    for (int n = 0; n < 9; n++) begin
      applyStimulus();
      checkOutput($sformatf("t4_drain%0d", n));
    end

    // Coordinate extremes: no wrap far away, hit near zero.
    ux[0] = 2; uy[0] = 2; px[0] = 1020; py[0] = 1020;
    applyStimulus();
    checkOutput("t5_far");
    checkValue("t5_no_wrap", 32'(collect_pulse), 32'd0);
    px[0] = 0; py[0] = 0;
    applyStimulus();
    checkOutput("t5_zero");
    checkValue("t5_hit_zero", 32'(collect_pulse[0]), 32'd1);
    parkAll();

    // Freeze, then Reset mid-cooldown.
    px[0] = 500; py[0] = 800;
    applyStimulus();
    checkOutput("t6_collect");
    parkAll();
    ga = 0;
    for (int n = 0; n < 10; n++) begin
      applyStimulus();
      checkOutput($sformatf("t6_frozen%0d", n));
    end
    ga = 1;
    applyStimulus();
    checkOutput("t6_resume");
    rst = 1;
    applyStimulus();
    checkOutput("t6_reset");
    checkValue("t6_reset_visible", 32'(pickup_visible), 32'hF);
    checkValue("t6_reset_rem", 32'(effect_remaining), 32'd0);
    rst = 0;

    // Randomized frames in a small arena, with occasional edge coordinates.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NPL; i++) begin
        px[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 60));
        py[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 60));
      end
      for (int j = 0; j < NPK; j++) begin
        ux[j] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 60));
        uy[j] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 60));
      end
      psz = int'($urandom_range(0, 8));
      usz = int'($urandom_range(0, 8));
      ga  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 49) == 0);
      applyStimulus();
      checkOutput($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
